gpu_rect_scheduler: RTL
=======================

// Module: gpu_rect_scheduler
// PURPOSE
//  Shares the single rectangle-fill rasterizer between two command requesters
//  (req0 = host command decoder, req1 = blit/clear engine) with round-robin arbitration.
//  Normalizes and clips each command, sequences the rasterizer's level start/done
//  protocol, and reports completion per requester. Sits between command decode and fill unit.
// PARAMETERS
//  WIDTH_BITS   `WIDTH_BITS   x coordinate width
//  HEIGHT_BITS  `HEIGHT_BITS  y coordinate width
//  X_MAX        `WIDTH-1      largest legal x; larger values clipped to this
//  Y_MAX        `HEIGHT-1     largest legal y; larger values clipped to this
//  TIMEOUT_CYC  2**20         watchdog limit in cycles (GPU_RECT_TIMEOUT_EN only)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous active-high reset
//  reqN_valid in   1   (N=0,1) command present
//  reqN_ready out  1   (N=0,1) one-cycle accept; payload captured when valid&ready
//  reqN_x1/x2 in   WIDTH_BITS   (N=0,1) corner x
//  reqN_y1/y2 in   HEIGHT_BITS  (N=0,1) corner y
//  fr_x1_o/fr_x2_o out WIDTH_BITS   normalized corners to rasterizer
//  fr_y1_o/fr_y2_o out HEIGHT_BITS  normalized corners to rasterizer
//  fr_start_o out  1   level start to rasterizer (rising edge launches, held high during run)
//  fr_done_i  in   1   rasterizer one-cycle completion pulse
//  grant_o    out  1   id of requester owning rasterizer (valid while busy_o)
//  busy_o     out  1   command in flight (LOAD..DONE)
//  cmd_done_o out  2   one-cycle pulse, bit N = requester N's command finished
//  err_o      out  1   sticky watchdog abort flag (tied 0 without GPU_RECT_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, fr_* corners 0, state IDLE, rr pointer = req0 preferred.
//  - FSM IDLE->ARB->LOAD->START->RUN->DONE->GAP->IDLE:
//    IDLE: if any valid -> ARB. ARB: pick winner (rr pointer breaks ties), assert its ready
//    for exactly this cycle, capture payload, set grant_o, toggle rr pointer to other req.
//    LOAD: drive normalized corners, fr_start_o=0, busy_o=1.
//    START: fr_start_o=1 (corners stable >=1 cycle before edge). -> RUN.
//    RUN: fr_start_o held 1; on fr_done_i -> DONE.
//    DONE: fr_start_o=0, cmd_done_o[grant]=1 for one cycle, busy_o=0. -> GAP.
//    GAP: fr_start_o=0 one extra cycle so next rising edge is detected. -> IDLE.
//  - Min latency accept->fr_start_o rise = 2 cycles; back-to-back start spacing >= 3 low cycles.
//  - Normalize: if x1>x2 swap x; if y1>y2 swap y; then clip each to X_MAX/Y_MAX (unsigned compare).
//  - Degenerate x1==x2 and y1==y2 passed unchanged (single pixel).
//  - Only one reqN_ready high per cycle; never high outside ARB.
//  - Both valid in ARB: winner = rr pointer; loser waits, wins next ARB if still valid.
//  - valid dropped before grant: not an error; no command recorded.
//  - fr_done_i outside RUN: ignored.
//  - rst mid-operation: next edge returns to reset values; fr_start_o low; in-flight cmd dropped,
//    no cmd_done_o pulse.
//  - Corners held constant from LOAD through DONE regardless of reqN_* changes.
// CONFIGURATION
//  GPU_RECT_TIMEOUT_EN defined: 21-bit counter clears on START, counts in RUN; reaching
//   TIMEOUT_CYC -> DONE path with cmd_done_o suppressed, err_o set (sticky until rst).
//  Undefined: no counter; RUN waits indefinitely for fr_done_i; err_o constant 0.
// TESTING
//  1. req0 (10,5)-(3,2) -> corners (3,2)-(10,5); start rises 2 cycles after ready; done -> cmd_done_o=01.
//  2. req0,req1 valid same cycle after reset -> req0 granted first, req1 next; cmd_done_o 01 then 10.
//  3. req1 x2=2000,y2=900 (640x480) -> fr_x2_o=639, fr_y2_o=479.
//  4. Back-to-back req0 cmds -> fr_start_o low >=3 cycles between runs; each run one start edge.
//  5. rst asserted in RUN -> next cycle fr_start_o=0, busy_o=0, no cmd_done_o; fresh cmd then works.
//  6. TIMEOUT_EN, TIMEOUT_CYC=64, fr_done_i never -> err_o=1 at cycle 64 of RUN, FSM back to IDLE.

Source files
------------

// File: rtl/gpu_rect_scheduler_if.sv
// Requester-side command channel for gpu_rect_scheduler.
// Ports: valid, ready (accept when both high), x1/x2, y1/y2 corners.
interface gpu_rect_scheduler_if #(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10
);
    logic                   valid;
    logic                   ready;
    logic [WIDTH_BITS-1:0]  x1;
    logic [WIDTH_BITS-1:0]  x2;
    logic [HEIGHT_BITS-1:0] y1;
    logic [HEIGHT_BITS-1:0] y2;

    modport master (output valid, x1, x2, y1, y2, input ready);
    modport slave  (input valid, x1, x2, y1, y2, output ready);
endinterface

// File: rtl/gpu_rect_scheduler.sv
// Round-robin scheduler sharing one rectangle-fill rasterizer between two
// requesters; normalizes/clips corners and runs the level start/done protocol.
// Ports: clk, rst (sync, active high); req0/req1 command channels (slave);
// fr_x1_o/fr_x2_o/fr_y1_o/fr_y2_o corners, fr_start_o level start, fr_done_i
// completion pulse; grant_o owner id, busy_o, cmd_done_o per-requester pulse,
// err_o sticky watchdog abort.
// Option: define GPU_RECT_TIMEOUT_EN to enable the RUN-state watchdog.
module gpu_rect_scheduler #(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int X_MAX       = 639,
`ifdef GPU_RECT_TIMEOUT_EN
    parameter int Y_MAX       = 479,
    parameter int TIMEOUT_CYC = 2**20
`else
    parameter int Y_MAX       = 479
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    gpu_rect_scheduler_if.slave    req0,
    gpu_rect_scheduler_if.slave    req1,
    output logic [WIDTH_BITS-1:0]  fr_x1_o,
    output logic [WIDTH_BITS-1:0]  fr_x2_o,
    output logic [HEIGHT_BITS-1:0] fr_y1_o,
    output logic [HEIGHT_BITS-1:0] fr_y2_o,
    output logic                   fr_start_o,
    input  logic                   fr_done_i,
    output logic                   grant_o,
    output logic                   busy_o,
    output logic [1:0]             cmd_done_o,
    output logic                   err_o
);
    localparam logic [WIDTH_BITS-1:0]  X_LIM = WIDTH_BITS'(X_MAX);
    localparam logic [HEIGHT_BITS-1:0] Y_LIM = HEIGHT_BITS'(Y_MAX);

    typedef enum logic [2:0] {
        IDLE, ARB, LOAD, START, RUN, DONE, GAP
    } state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;
    logic   grant_q, grant_d;
    logic [WIDTH_BITS-1:0]  x1_q, x1_d, x2_q, x2_d;
    logic [HEIGHT_BITS-1:0] y1_q, y1_d, y2_q, y2_d;

    logic timeout_hit;
    logic cmd_ok;

    logic                   win;
    logic [WIDTH_BITS-1:0]  sx1, sx2, nx_lo, nx_hi;
    logic [HEIGHT_BITS-1:0] sy1, sy2, ny_lo, ny_hi;

    // Winner: rr pointer only matters when both requesters are valid.
    always_comb begin
        win = (req0.valid && req1.valid) ? rr_q : req1.valid;
        sx1 = win ? req1.x1 : req0.x1;
        sx2 = win ? req1.x2 : req0.x2;
        sy1 = win ? req1.y1 : req0.y1;
        sy2 = win ? req1.y2 : req0.y2;
        nx_lo = (sx1 > sx2) ? sx2 : sx1;
        nx_hi = (sx1 > sx2) ? sx1 : sx2;
        ny_lo = (sy1 > sy2) ? sy2 : sy1;
        ny_hi = (sy1 > sy2) ? sy1 : sy2;
        if (nx_lo > X_LIM) nx_lo = X_LIM;
        if (nx_hi > X_LIM) nx_hi = X_LIM;
        if (ny_lo > Y_LIM) ny_lo = Y_LIM;
        if (ny_hi > Y_LIM) ny_hi = Y_LIM;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        req0.ready = 1'b0;
        req1.ready = 1'b0;
        fr_start_o = 1'b0;
        busy_o     = 1'b0;
        cmd_done_o = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (req0.valid || req1.valid) state_d = ARB;
            end
            ARB: begin
                // A requester that withdrew before this cycle is simply skipped.
                if (req0.valid || req1.valid) begin
                    req0.ready = ~win;
                    req1.ready = win;
                    grant_d    = win;
                    rr_d       = ~win;
                    x1_d       = nx_lo;
                    x2_d       = nx_hi;
                    y1_d       = ny_lo;
                    y2_d       = ny_hi;
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                busy_o  = 1'b1;
                state_d = START;
            end
            START: begin
                busy_o     = 1'b1;
                fr_start_o = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                busy_o     = 1'b1;
                fr_start_o = 1'b1;
                if (fr_done_i || timeout_hit) state_d = DONE;
            end
            DONE: begin
                if (cmd_ok) cmd_done_o = grant_q ? 2'b10 : 2'b01;
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
        end
    end

`ifdef GPU_RECT_TIMEOUT_EN
    logic [20:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;

    // Fires on the TIMEOUT_CYC-th RUN cycle; a same-cycle done wins.
    assign timeout_hit = (state_q == RUN) && !fr_done_i
                         && (cnt_q == 21'(TIMEOUT_CYC - 1));
    assign cmd_ok = ~abort_q;
    assign err_o  = err_q;

    always_comb begin
        cnt_d   = cnt_q;
        abort_d = abort_q;
        err_d   = err_q;
        if (state_q == START) begin
            cnt_d   = '0;
            abort_d = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 21'd1;
            if (timeout_hit) begin
                abort_d = 1'b1;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign cmd_ok      = 1'b1;
    assign err_o       = 1'b0;
`endif

    assign grant_o = grant_q;
    assign fr_x1_o = x1_q;
    assign fr_x2_o = x2_q;
    assign fr_y1_o = y1_q;
    assign fr_y2_o = y2_q;
endmodule
